imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, handshaked immediate generator for the decode stage. It takes a 32-bit RISC-V instruction word and produces the format-tagged, sign-/zero-extended immediate at a configurable datapath width (RV32/RV64). Output is registered, with a 2-entry skid buffer, so decode can be split across a pipeline boundary.

## Interface
- Parameters:
  - `XLEN`, default 32: datapath/immediate width; legal values 32 or 64.
  - `TAG_W`, default 8: width of the sideband tag carried alongside each instruction (PC index, ROB id, etc.).
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  input  1  clock; all state updates on the rising edge.
  - `rst_n`  input  1  asynchronous active-low reset.
- Upstream side:
  - `in_valid`  input  1  instruction presented.
  - `in_ready`  output  1  stage can accept this cycle.
  - `in_inst`  input  32  instruction word.
  - `in_tag`  input  TAG_W  sideband, passed through unchanged.
- Downstream side:
  - `out_valid`  output  1  result valid.
  - `out_ready`  input  1  consumer accepts.
  - `out_imm`  output  XLEN  immediate.
  - `out_fmt`  output  3  format, `imm_fmt_e`.
  - `out_tag`  output  TAG_W  tag of the result.

## Operation
- The `out_fmt` encoding is:
  - NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7.
- Decode by opcode `inst[6:0]`. `sext()` means sign-extend from `inst[31]` to XLEN.
  - LOAD 0000011, JALR 1100111, and OP-IMM 0010011 with funct3 ∉ {001,101}: I, `sext(inst[31:20])`.
  - OP-IMM funct3 001/101 (shifts): SH, zero-extended shamt.
    - XLEN=32: `inst[24:20]`.
    - XLEN=64: `inst[25:20]`.
    - The funct7 bits (e.g. SRAI bit 30) never appear in `out_imm`.
  - OP-IMM-32 0011011: only when XLEN=64.
    - Shifts: SH with `inst[24:20]`.
    - Otherwise: I.
    - When XLEN=32: NONE.
  - STORE 0100011: S, `sext({inst[31:25],inst[11:7]})`.
  - BRANCH 1100011: B, `sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})`.
  - JAL 1101111: J, `sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})`.
  - LUI 0110111 and AUIPC 0010111: U, `sext({inst[31:12],12'b0})`. At XLEN=64 the upper 32 bits replicate bit 31.
  - Any other opcode: NONE, `out_imm` = 0.
- Pipeline: output register (OR) plus skid register (SR), with strict in-order delivery.
  - `in_ready = !sr_valid`.
  - Input accepted (`in_valid && in_ready`):
    - Goes to OR if OR is empty or draining (`out_ready`).
    - Otherwise goes to SR.
  - On OR drain with SR full: SR moves to OR the same edge. The new input cannot be accepted that cycle, because `in_ready` was low.
  - `out_*` are stable while `out_valid && !out_ready`.
- Boundary cases:
  - SR full and OR stalled: `in_ready` = 0. Upstream must hold its data.
  - Simultaneous accept and drain with SR empty: the new result replaces OR. No bubble.
  - Reset asserted mid-transfer: both entries are discarded immediately (asynchronous). No partial output.

## Timing
- Reset values:
  - `out_valid` = 0, `out_imm` = 0, `out_fmt` = NONE, `out_tag` = 0.
  - `in_ready` = 1. SR is empty.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle with `out_ready` held high.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`.

## Configuration
- `IMM_GEN_CSR_EN`, when defined:
  - SYSTEM 1110011 with funct3 ∈ {101,110,111} gives Z with `out_imm` = zero-extended `inst[19:15]` (CSR zimm).
  - Other SYSTEM encodings give NONE.
- When undefined: all SYSTEM opcodes give NONE with `out_imm` = 0.

## Structure
- Package `imm_pkg` holds:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, …, OPC_SYSTEM);
  - the `imm_fmt_e` enum (3-bit);
  - the funct3 shift constants.
- Sub-module `imm_decode` is purely combinational: inst in, `{imm, fmt}` out, XLEN parameter.
- `imm_gen_stage` wraps `imm_decode` and holds the OR/SR handshake logic.

## Test plan
- XLEN=32, `out_ready` = 1:
  - 0xFFF00093 (addi x1,x0,-1): imm 0xFFFFFFFF, fmt I.
  - 0xFE112E23 (sw x1,-4(x2)): imm 0xFFFFFFFC, fmt S.
  - Both results 1 cycle after accept.
- 0x4030D093 (srai x1,x1,3): imm 0x00000003, fmt SH. Bit 30 must not leak.
- 0x800000B7 (lui x1,0x80000):
  - XLEN=32: imm 0x80000000.
  - XLEN=64: imm 0xFFFFFFFF80000000.
  - fmt U in both.
- 0x3002D073 (csrrwi x0,mstatus,5):
  - With `IMM_GEN_CSR_EN`: imm 0x5, fmt Z.
  - Without: imm 0, fmt NONE.
- Backpressure, tags 1,2,3 pushed back-to-back while `out_ready` = 0 for 3 cycles:
  - Tag 1 held in OR, tag 2 in SR.
  - `in_ready` = 0 with tag 3 waiting.
  - On release, outputs tags 1,2,3 on consecutive cycles, with none lost or duplicated.
- Reset: assert `rst_n` low with OR and SR full.
  - `out_valid` drops immediately and `in_ready` = 1.
  - After release, the first new instruction appears with 1-cycle latency.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: RISC-V opcodes, shift funct3
// codes and the immediate format tag.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instruction word in, {imm, fmt} out at XLEN.
// CSR zimm decode for SYSTEM opcodes is enabled by defining IMM_GEN_CSR_EN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt, shamt_w;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign opc     = inst[6:0];
  assign f3      = inst[14:12];
  assign imm_i   = sext({{20{inst[31]}}, inst[31:20]});
  assign imm_s   = sext({{20{inst[31]}}, inst[31:25], inst[11:7]});
  assign imm_b   = sext({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
  assign imm_j   = sext({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
  assign imm_u   = sext({inst[31:12], 12'b0});
  // RV64 shifts use a 6-bit shamt; funct7 bits above it are never forwarded.
  assign shamt   = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
  assign shamt_w = XLEN'(inst[24:20]);

  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        imm = imm_i;
        fmt = FMT_I;
      end
      OPC_OPIMM: begin
        if (is_shift(f3)) begin
          imm = shamt;
          fmt = FMT_SH;
        end else begin
          imm = imm_i;
          fmt = FMT_I;
        end
      end
      OPC_OPIMM32: begin
        if (XLEN != 64) begin
          imm = '0;
          fmt = FMT_NONE;
        end else if (is_shift(f3)) begin
          imm = shamt_w;
          fmt = FMT_SH;
        end else begin
          imm = imm_i;
          fmt = FMT_I;
        end
      end
      OPC_STORE: begin
        imm = imm_s;
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = imm_b;
        fmt = FMT_B;
      end
      OPC_JAL: begin
        imm = imm_j;
        fmt = FMT_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = imm_u;
        fmt = FMT_U;
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        if ((f3 == 3'b101) || (f3 == 3'b110) || (f3 == 3'b111)) begin
          imm = XLEN'(inst[19:15]);
          fmt = FMT_Z;
        end else begin
          imm = '0;
          fmt = FMT_NONE;
        end
`else
        imm = '0;
        fmt = FMT_NONE;
`endif
      end
      default: begin
        imm = '0;
        fmt = FMT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: imm_decode followed by an output
// register and a skid register with in-order valid/ready handshaking.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             accept;

  logic             or_valid_q, or_valid_d, sr_valid_q, sr_valid_d;
  logic [XLEN-1:0]  or_imm_q, or_imm_d, sr_imm_q, sr_imm_d;
  imm_fmt_e         or_fmt_q, or_fmt_d, sr_fmt_q, sr_fmt_d;
  logic [TAG_W-1:0] or_tag_q, or_tag_d, sr_tag_q, sr_tag_d;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst (in_inst),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  // in_ready comes straight from the skid flag, so out_ready never reaches it.
  assign in_ready  = !sr_valid_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = or_valid_q;
  assign out_imm   = or_imm_q;
  assign out_fmt   = or_fmt_q;
  assign out_tag   = or_tag_q;

  always_comb begin
    or_valid_d = or_valid_q;
    or_imm_d   = or_imm_q;
    or_fmt_d   = or_fmt_q;
    or_tag_d   = or_tag_q;
    sr_valid_d = sr_valid_q;
    sr_imm_d   = sr_imm_q;
    sr_fmt_d   = sr_fmt_q;
    sr_tag_d   = sr_tag_q;
    if (sr_valid_q) begin
      // Skid full implies OR full; a drain promotes the skid entry.
      if (out_ready) begin
        or_valid_d = 1'b1;
        or_imm_d   = sr_imm_q;
        or_fmt_d   = sr_fmt_q;
        or_tag_d   = sr_tag_q;
        sr_valid_d = 1'b0;
      end else begin
        sr_valid_d = 1'b1;
      end
    end else if (accept) begin
      if (!or_valid_q || out_ready) begin
        or_valid_d = 1'b1;
        or_imm_d   = dec_imm;
        or_fmt_d   = dec_fmt;
        or_tag_d   = in_tag;
      end else begin
        sr_valid_d = 1'b1;
        sr_imm_d   = dec_imm;
        sr_fmt_d   = dec_fmt;
        sr_tag_d   = in_tag;
      end
    end else if (out_ready) begin
      or_valid_d = 1'b0;
    end else begin
      or_valid_d = or_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_imm_q   <= '0;
      or_fmt_q   <= FMT_NONE;
      or_tag_q   <= '0;
      sr_valid_q <= 1'b0;
      sr_imm_q   <= '0;
      sr_fmt_q   <= FMT_NONE;
      sr_tag_q   <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      or_imm_q   <= or_imm_d;
      or_fmt_q   <= or_fmt_d;
      or_tag_q   <= or_tag_d;
      sr_valid_q <= sr_valid_d;
      sr_imm_q   <= sr_imm_d;
      sr_fmt_q   <= sr_fmt_d;
      sr_tag_q   <= sr_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed vectors, backpressure/reset sequences and
// randomized traffic on RV32 and RV64 instances checked against a field-level model.
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [31:0] in_inst;
  logic [7:0]  in_tag;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  imm_fmt_e    out_fmt32, out_fmt64;
  logic [7:0]  out_tag32, out_tag64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: immediates rebuilt as integers from the instruction fields.
  function automatic void ref_model(input logic [31:0] inst, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt);
    longint v;
    logic [6:0] opc;
    logic [2:0] f3;
    opc = inst[6:0];
    f3  = inst[14:12];
    v   = 0;
    fmt = 3'd0;
    if (opc == 7'b0000011 || opc == 7'b1100111 ||
        ((opc == 7'b0010011 || (opc == 7'b0011011 && xlen == 64)) && f3 != 3'd1 && f3 != 3'd5)) begin
      fmt = 3'd1;
      v = longint'(inst[31:20]);
      if (v >= 2048) v = v - 4096;
    end else if (opc == 7'b0010011) begin
      fmt = 3'd6;
      v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
    end else if (opc == 7'b0011011 && xlen == 64) begin
      fmt = 3'd6;
      v = longint'(inst[24:20]);
    end else if (opc == 7'b0100011) begin
      fmt = 3'd2;
      v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
      if (v >= 2048) v = v - 4096;
    end else if (opc == 7'b1100011) begin
      fmt = 3'd3;
      v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
          longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
      if (v >= 4096) v = v - 8192;
    end else if (opc == 7'b1101111) begin
      fmt = 3'd5;
      v = longint'(inst[31]) * (64'd1 << 20) + longint'(inst[19:12]) * 4096 +
          longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
      if (v >= (64'd1 << 20)) v = v - (64'd1 << 21);
    end else if (opc == 7'b0110111 || opc == 7'b0010111) begin
      fmt = 3'd4;
      v = longint'(inst[31:12]) * 4096;
      if (v >= (64'd1 << 31)) v = v - (64'd1 << 32);
`ifdef IMM_GEN_CSR_EN
    end else if (opc == 7'b1110011 && f3 >= 3'd5) begin
      fmt = 3'd7;
      v = longint'(inst[19:15]);
`endif
    end
    imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
  } vec_t;
  vec_t tbl[$];

  logic [6:0] opcs [12] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0011011, 7'b0100011,
                            7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011,
                            7'b0110011, 7'b1111111};

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opcs[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q_inst[$];
    logic [7:0]  q_tag[$];
    logic [7:0]  got[$];
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        acc;
    logic [7:0]  tag_cnt;

    tbl.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1});
    tbl.push_back('{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2});
    tbl.push_back('{32'h4030D093, 32'h00000003, 3'd6, 64'h0000000000000003, 3'd6});
    tbl.push_back('{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4});
    tbl.push_back('{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5});
    tbl.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3});
    tbl.push_back('{32'h0010809B, 32'h00000000, 3'd0, 64'h0000000000000001, 3'd1});
    tbl.push_back('{32'h03F09093, 32'h0000001F, 3'd6, 64'h000000000000003F, 3'd6});
    tbl.push_back('{32'h00000073, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0});
    tbl.push_back('{32'h0000007F, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0});
`ifdef IMM_GEN_CSR_EN
    tbl.push_back('{32'h3002D073, 32'h00000005, 3'd7, 64'h0000000000000005, 3'd7});
`else
    tbl.push_back('{32'h3002D073, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0});
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'h0; in_tag = 8'h0;
    #12;
    chk("rst out_valid", {63'h0, out_valid32}, 64'h0);
    chk("rst in_ready", {63'h0, in_ready32}, 64'h1);
    chk("rst out_imm", {32'h0, out_imm32}, 64'h0);
    chk("rst out_fmt", {61'h0, out_fmt32}, 64'h0);
    chk("rst out_tag", {56'h0, out_tag32}, 64'h0);
    chk("rst out_imm64", out_imm64, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors: one instruction per slot, result expected one edge later.
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_inst = tbl[i].inst; in_tag = 8'(i + 16); out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d valid", i), {62'h0, out_valid32, out_valid64}, 64'h3);
      chk($sformatf("vec%0d imm32", i), {32'h0, out_imm32}, {32'h0, tbl[i].imm32});
      chk($sformatf("vec%0d fmt32", i), {61'h0, out_fmt32}, {61'h0, tbl[i].fmt32});
      chk($sformatf("vec%0d imm64", i), out_imm64, tbl[i].imm64);
      chk($sformatf("vec%0d fmt64", i), {61'h0, out_fmt64}, {61'h0, tbl[i].fmt64});
      chk($sformatf("vec%0d tag", i), {56'h0, out_tag32}, 64'(i + 16));
    end
    @(posedge clk); #1;

    // Backpressure: tags 1,2,3 pushed while the consumer stalls.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 8'd1;
    @(posedge clk); #1; in_tag = 8'd2;
    @(posedge clk); #1; in_tag = 8'd3;
    @(negedge clk);
    chk("bp or tag", {56'h0, out_tag32}, 64'd1);
    chk("bp in_ready", {63'h0, in_ready32}, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp hold tag", {55'h0, out_valid32, out_tag32}, {55'h0, 1'b1, 8'd1});
    chk("bp hold in_ready", {63'h0, in_ready32}, 64'h0);
    @(posedge clk); #1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid32 && out_ready) got.push_back(out_tag32);
      acc = in_valid && in_ready32;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp order%0d", k), (k < got.size()) ? {56'h0, got[k]} : 64'hDEAD, 64'(k + 1));

    // Reset with both entries full.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFE112E23; in_tag = 8'd4;
    @(posedge clk); #1; in_tag = 8'd5;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("prerst full", {62'h0, out_valid32, in_ready32}, 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {62'h0, out_valid32, out_valid64}, 64'h0);
    chk("midrst in_ready", {62'h0, in_ready32, in_ready64}, 64'h3);
    chk("midrst out_tag", {56'h0, out_tag32}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst empty", {63'h0, out_valid32}, 64'h0);
    in_valid = 1'b1; in_inst = 32'hFE112E23; in_tag = 8'd6; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("postrst valid", {63'h0, out_valid32}, 64'h1);
    chk("postrst tag", {56'h0, out_tag32}, 64'd6);
    chk("postrst imm", {32'h0, out_imm32}, 64'hFFFFFFFC);
    @(posedge clk); #1;

    // Randomized traffic against the model with a FIFO scoreboard.
    tag_cnt = 8'd0; acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inst  = rand_inst();
        in_tag   = tag_cnt;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready32;
      if (in_ready32 !== in_ready64 || out_valid32 !== out_valid64)
        chk("rnd xlen agree", {62'h0, in_ready64, out_valid64}, {62'h0, in_ready32, out_valid32});
      if (out_valid32 && out_ready) begin
        if (q_inst.size() == 0) begin
          chk("rnd unexpected output", 64'h1, 64'h0);
        end else begin
          ref_model(q_inst[0], 32, e_imm, e_fmt);
          chk("rnd imm32", {32'h0, out_imm32}, e_imm);
          chk("rnd fmt32", {61'h0, out_fmt32}, {61'h0, e_fmt});
          ref_model(q_inst[0], 64, e_imm, e_fmt);
          chk("rnd imm64", out_imm64, e_imm);
          chk("rnd fmt64", {61'h0, out_fmt64}, {61'h0, e_fmt});
          chk("rnd tag", {48'h0, out_tag32, out_tag64}, {48'h0, q_tag[0], q_tag[0]});
          void'(q_inst.pop_front());
          void'(q_tag.pop_front());
        end
      end
      if (acc) begin
        q_inst.push_back(in_inst);
        q_tag.push_back(in_tag);
        tag_cnt = tag_cnt + 8'd1;
      end
      @(posedge clk); #1;
    end

    // Drain with the consumer always ready.
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid32 && q_inst.size() != 0) begin
        ref_model(q_inst[0], 32, e_imm, e_fmt);
        chk("drain imm32", {32'h0, out_imm32}, e_imm);
        chk("drain tag", {56'h0, out_tag32}, {56'h0, q_tag[0]});
        void'(q_inst.pop_front());
        void'(q_tag.pop_front());
      end
      @(posedge clk); #1;
    end
    chk("drain empty", 64'(q_inst.size()), 64'd0);
    chk("drain out_valid", {63'h0, out_valid32}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
